// File: rtl/dterm_pkg.sv
// Shared defaults and helpers for the PID term blocks.
// The saturation helper clamps a signed value to a signed width of out_w bits.
package dterm_pkg;

  localparam int ERR_W_DEF     = 10;
  localparam int DIFF_W_DEF    = 8;
  localparam int COEFF_W_DEF   = 5;
  localparam int DEPTH_DEF     = 3;
  localparam int NCH_DEF       = 2;
  localparam int COEFF_RST_DEF = 7;

  function automatic int sat_s(input int val, input int out_w);
    int hi;
    int lo;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/dterm_if.sv
// Sample, coefficient, flush and result signals of the derivative term block.
interface dterm_if #(
  parameter int ERR_W   = 10,
  parameter int DIFF_W  = 8,
  parameter int COEFF_W = 5,
  parameter int CH_W    = 1
);
  logic signed [ERR_W-1:0]          err_sat;
  logic        [CH_W-1:0]           err_ch;
  logic                             err_vld;
  logic                             coeff_wr;
  logic signed [COEFF_W-1:0]        coeff_in;
  logic                             clr;
  logic        [CH_W-1:0]           clr_ch;
  logic signed [DIFF_W+COEFF_W-1:0] D_term;
  logic                             D_vld;
  logic        [CH_W-1:0]           D_ch;

  modport master (
    output err_sat, err_ch, err_vld, coeff_wr, coeff_in, clr, clr_ch,
    input  D_term, D_vld, D_ch
  );

  modport slave (
    input  err_sat, err_ch, err_vld, coeff_wr, coeff_in, clr, clr_ch,
    output D_term, D_vld, D_ch
  );
endinterface

// File: rtl/dterm_hist.sv
// One channel's sample history: DEPTH-deep shift register plus a prime counter
// that saturates at DEPTH once the oldest entry holds a real sample.
module dterm_hist
  import dterm_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_shift,
  input  logic                    i_clr,
  input  logic signed [ERR_W-1:0] i_sample,
  output logic signed [ERR_W-1:0] o_oldest,
  output logic                    o_primed
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic signed [ERR_W-1:0] r_hist [DEPTH];
  logic        [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_hist[0] <= i_sample;
      for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
      if (r_cnt != CNT_W'(DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_oldest = r_hist[DEPTH-1];
  assign o_primed = (r_cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/dterm_mc.sv
// Multi-channel derivative term: saturated (sample - sample DEPTH back) times
// a programmable coefficient, two-stage pipeline, one result per accepted sample.
module dterm_mc
  import dterm_pkg::*;
#(
  parameter int ERR_W     = ERR_W_DEF,
  parameter int DIFF_W    = DIFF_W_DEF,
  parameter int COEFF_W   = COEFF_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int COEFF_RST = COEFF_RST_DEF
) (
  input logic    clk,
  input logic    rst_n,
  dterm_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int P_W  = DIFF_W + COEFF_W;

  logic                      w_acc;
  logic signed [ERR_W-1:0]   w_oldest_arr [NCH];
  logic        [NCH-1:0]     w_primed_arr;
  logic signed [ERR_W-1:0]   w_oldest;
  logic                      w_primed;
  logic signed [ERR_W:0]     w_diff;
  logic signed [DIFF_W-1:0]  w_diff_sat;
  logic signed [P_W-1:0]     w_prod;

  logic                      r_s1_vld;
  logic signed [DIFF_W-1:0]  r_s1_diff;
  logic        [CH_W-1:0]    r_s1_ch;
  logic signed [COEFF_W-1:0] r_s1_coeff;
  logic                      r_s1_primed;
  logic signed [COEFF_W-1:0] r_coeff;
  logic signed [P_W-1:0]     r_d_term;
  logic                      r_d_vld;
  logic        [CH_W-1:0]    r_d_ch;

  // A flush of the sample's own channel wins over the sample.
  always_comb begin
    w_acc = bus.err_vld && (int'(bus.err_ch) < NCH) &&
            !(bus.clr && (bus.clr_ch == bus.err_ch));
  end

  always_comb begin
    w_oldest = '0;
    w_primed = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.err_ch == CH_W'(c)) begin
        w_oldest = w_oldest_arr[c];
        w_primed = w_primed_arr[c];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      dterm_hist #(.ERR_W(ERR_W), .DEPTH(DEPTH)) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_shift  (w_acc && (bus.err_ch == CH_W'(g))),
        .i_clr    (bus.clr && (bus.clr_ch == CH_W'(g))),
        .i_sample (bus.err_sat),
        .o_oldest (w_oldest_arr[g]),
        .o_primed (w_primed_arr[g])
      );
    end
  endgenerate

  assign w_diff     = $signed({bus.err_sat[ERR_W-1], bus.err_sat}) -
                      $signed({w_oldest[ERR_W-1], w_oldest});
  assign w_diff_sat = DIFF_W'(sat_s(int'(w_diff), DIFF_W));
  assign w_prod     = $signed(P_W'(r_s1_diff)) * $signed(P_W'(r_s1_coeff));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coeff     <= COEFF_W'(COEFF_RST);
      r_s1_vld    <= 1'b0;
      r_s1_diff   <= '0;
      r_s1_ch     <= '0;
      r_s1_coeff  <= '0;
      r_s1_primed <= 1'b0;
      r_d_term    <= '0;
      r_d_vld     <= 1'b0;
      r_d_ch      <= '0;
    end else begin
      if (bus.coeff_wr) r_coeff <= bus.coeff_in;
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_diff   <= w_diff_sat;
        r_s1_ch     <= bus.err_ch;
        r_s1_coeff  <= r_coeff;
        r_s1_primed <= w_primed;
      end
      r_d_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_d_term <= r_s1_primed ? w_prod : '0;
        r_d_ch   <= r_s1_ch;
      end
    end
  end

  assign bus.D_term = r_d_term;
  assign bus.D_vld  = r_d_vld;
  assign bus.D_ch   = r_d_ch;

endmodule

// File: tb/tb_dterm_mc.sv
// Directed table-driven bench for dterm_mc with default parameters (coeff 7).
// Row j's expected outputs are the results of row j-2's inputs.
module tb_dterm_mc;
  localparam int ERR_W   = 10;
  localparam int DIFF_W  = 8;
  localparam int COEFF_W = 5;
  localparam int CH_W    = 1;

  typedef struct {
    bit vld; int ch; int err;
    bit cw;  int ci;
    bit clr; int cc;
    bit rst_n;
    bit ev;  int et; int ech; bit chk;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  dterm_if #(.ERR_W(ERR_W), .DIFF_W(DIFF_W), .COEFF_W(COEFF_W), .CH_W(CH_W)) bus ();

  dterm_mc u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit vld, input int ch, input int err,
                     input bit cw, input int ci, input bit clr, input int cc,
                     input bit rst, input bit ev, input int et, input int ech,
                     input bit ck);
    vec_t v;
    v = '{vld, ch, err, cw, ci, clr, cc, rst, ev, et, ech, ck};
    vecs.push_back(v);
  endtask

  task automatic smp(input int ch, input int err, input bit ev, input int et,
                     input int ech, input bit ck);
    add(1, ch, err, 0, 0, 0, 0, 1, ev, et, ech, ck);
  endtask

  task automatic idl(input bit ev, input int et, input int ech, input bit ck);
    add(0, 0, 0, 0, 0, 0, 0, 1, ev, et, ech, ck);
  endtask

  task automatic drive_idle();
    bus.err_vld  = 1'b0;
    bus.err_sat  = '0;
    bus.err_ch   = '0;
    bus.coeff_wr = 1'b0;
    bus.coeff_in = '0;
    bus.clr      = 1'b0;
    bus.clr_ch   = '0;
  endtask

  initial begin
    int lat;
    // back-to-back ch0 ramp
    smp(0, 10, 0, 0, 0, 0);
    smp(0, 20, 0, 0, 0, 0);
    smp(0, 30, 1, 0, 0, 1);
    smp(0, 40, 1, 0, 0, 1);
    idl(1, 0, 0, 1);
    idl(1, 210, 0, 1);
    idl(0, 210, 0, 1);
    // saturation both ways
    smp(0, -512, 0, 0, 0, 0);
    smp(0, -512, 0, 0, 0, 0);
    smp(0, -512, 1, -896, 0, 1);
    smp(0, 511, 1, -896, 0, 1);
    smp(0, 511, 1, -896, 0, 1);
    smp(0, 511, 1, 889, 0, 1);
    smp(0, -512, 1, 889, 0, 1);
    idl(1, 889, 0, 1);
    idl(1, -896, 0, 1);
    // flush ch0, then interleave two channels
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    smp(0, 0, 0, 0, 0, 0);
    smp(1, 100, 0, 0, 0, 0);
    smp(0, 0, 1, 0, 0, 1);
    smp(1, 100, 1, 0, 1, 1);
    smp(0, 0, 1, 0, 0, 1);
    smp(1, 100, 1, 0, 1, 1);
    smp(0, 50, 1, 0, 0, 1);
    smp(1, 80, 1, 0, 1, 1);
    idl(1, 350, 0, 1);
    idl(1, -140, 1, 1);
    idl(0, -140, 1, 1);
    // coefficient write coincident with a sample
    add(1, 0, 30, 1, -3, 0, 0, 1, 0, 0, 0, 0);
    smp(0, 30, 0, 0, 0, 0);
    idl(1, 210, 0, 1);
    idl(1, -90, 0, 1);
    // flush ch0 against a same-cycle ch0 sample
    add(1, 0, 99, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    smp(1, 110, 0, 0, 0, 0);
    smp(0, 5, 0, -90, 0, 1);
    smp(0, 6, 1, -30, 1, 1);
    smp(0, 7, 1, 0, 0, 1);
    smp(0, 100, 1, 0, 0, 1);
    idl(1, 0, 0, 1);
    idl(1, -285, 0, 1);
    // reset with two samples in flight
    smp(1, 120, 0, 0, 0, 0);
    add(1, 1, 130, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idl(0, 0, 0, 1);
    idl(0, 0, 0, 1);
    smp(0, 0, 0, 0, 0, 1);
    smp(0, 0, 0, 0, 0, 0);
    smp(0, 0, 1, 0, 0, 1);
    smp(0, 20, 1, 0, 0, 1);
    idl(1, 0, 0, 1);
    idl(1, 140, 0, 1);

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset D_vld", int'(bus.D_vld), 0);
    chk("reset D_term", int'(bus.D_term), 0);
    chk("reset D_ch", int'(bus.D_ch), 0);
    rst_n = 1'b1;

    for (int j = 0; j < vecs.size(); j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("row%0d D_vld", j), int'(bus.D_vld), int'(vecs[j].ev));
      if (vecs[j].chk) begin
        chk($sformatf("row%0d D_term", j), int'(bus.D_term), vecs[j].et);
        chk($sformatf("row%0d D_ch", j), int'(bus.D_ch), vecs[j].ech);
      end
      bus.err_vld  = vecs[j].vld;
      bus.err_ch   = CH_W'(vecs[j].ch);
      bus.err_sat  = ERR_W'(vecs[j].err);
      bus.coeff_wr = vecs[j].cw;
      bus.coeff_in = COEFF_W'(vecs[j].ci);
      bus.clr      = vecs[j].clr;
      bus.clr_ch   = CH_W'(vecs[j].cc);
      rst_n        = vecs[j].rst_n;
    end

    // drain, then measure latency of a single unprimed ch1 sample
    @(posedge clk);
    #1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    bus.err_vld = 1'b1;
    bus.err_ch  = CH_W'(1);
    bus.err_sat = ERR_W'(77);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      bus.err_vld = 1'b0;
      lat++;
    end while (!bus.D_vld && lat < 8);
    chk("latency", lat, 2);
    chk("latency D_term", int'(bus.D_term), 0);
    chk("latency D_ch", int'(bus.D_ch), 1);
    @(posedge clk);
    #1;
    chk("single pulse D_vld", int'(bus.D_vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dterm_mc.md
DTERM_MC -- requirements
Module: dterm_mc

Interface
REQ-001 SHALL have parameter ERR_W, default 10: signed error input width.
REQ-002 SHALL have parameter DIFF_W, default 8: saturated difference width.
REQ-003 SHALL have parameter COEFF_W, default 5: signed coefficient width.
REQ-004 SHALL have parameter DEPTH, default 3: samples between current and previous error (history depth, >=1).
REQ-005 SHALL have parameter NCH, default 2: independent channels; CH_W = max(1, clog2(NCH)).
REQ-006 SHALL have parameter COEFF_RST, default 7: coefficient value after reset.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 SHALL have port err_sat, input, ERR_W signed: error sample.
REQ-010 SHALL have port err_ch, input, CH_W: channel of err_sat.
REQ-011 SHALL have port err_vld, input, 1: sample valid, one sample per cycle max.
REQ-012 SHALL have port coeff_wr, input, 1: load coeff_in.
REQ-013 SHALL have port coeff_in, input, COEFF_W signed: new D coefficient.
REQ-014 SHALL have port clr, input, 1: flush history of channel clr_ch.
REQ-015 SHALL have port clr_ch, input, CH_W: channel to flush.
REQ-016 SHALL have port D_term, output, DIFF_W+COEFF_W signed: derivative term.
REQ-017 SHALL have port D_vld, output, 1: D_term/D_ch valid, single-cycle pulse.
REQ-018 SHALL have port D_ch, output, CH_W: channel of D_term.

Function
REQ-019 SHALL keep per channel a DEPTH-entry history of accepted samples plus a prime count 0..DEPTH.
REQ-020 Sample accepted when err_vld=1, err_ch<NCH, and not (clr=1 and clr_ch=err_ch); otherwise ignored, no output, no state change.
REQ-021 On accept: diff = err_sat - oldest history entry of err_ch, computed at ERR_W+1 bits (no wrap).
REQ-022 diff SHALL saturate to [-2^(DIFF_W-1), 2^(DIFF_W-1)-1].
REQ-023 Stage 1 (edge after accept): register sat diff, channel, coefficient current at accept, primed flag (prime count==DEPTH before accept); shift sample into history; prime count increments, saturating at DEPTH.
REQ-024 Stage 2: D_term = sat diff * coefficient (signed, full width) if primed, else 0; D_vld=1, D_ch=channel.
REQ-025 Latency: D_vld asserts exactly 2 cycles after accepting edge's cycle; fully pipelined, back-to-back samples on same channel see history updated by the previous sample.
REQ-026 coeff_wr at cycle t: samples accepted at t use old coefficient, samples from t+1 use coeff_in.
REQ-027 clr: clr_ch history set to 0, prime count to 0 at next edge; in-flight outputs for that channel unaffected; out-of-range clr_ch ignored.
REQ-028 D_vld=0 cycles: D_term and D_ch hold last values.

Reset
REQ-029 rst_n=0 at an edge: all history 0, prime counts 0, coefficient COEFF_RST, pipeline valids 0, D_term 0, D_vld 0, D_ch 0.
REQ-030 Reset mid-operation SHALL discard in-flight samples; no D_vld after reset release for pre-reset samples.

Structure
REQ-031 Package dterm_pkg SHALL hold parameter defaults and a saturation function shared with other PID terms.
REQ-032 One sub-module dterm_hist SHALL implement a single channel's history shift register and prime counter, instantiated NCH times by generate.

Verification (defaults, coeff 7)
REQ-033 Reset; ch0 samples 10,20,30,40 back-to-back -> D_term 0,0,0 then 210, each D_vld 2 cycles after its err_vld, D_ch=0.
REQ-034 ch0 primed with three -512, then 511 -> diff 1023 saturates 127, D_term 889; primed 511, then -512 -> -128, D_term -896.
REQ-035 Alternate ch0 (0,0,0,50) and ch1 (100,100,100,80) interleaved -> ch0 350, ch1 -140, histories independent.
REQ-036 coeff_wr=1 coeff_in=-3 same cycle as primed ch0 diff 30, next sample diff 30 -> outputs 210 then -90.
REQ-037 clr=1 clr_ch=0 with err_vld ch0 same cycle, ch1 valid next -> no ch0 output, ch0 next three outputs 0, ch1 unaffected.
REQ-038 rst_n=0 one cycle while two samples in flight -> D_vld stays 0, D_term 0, coefficient back to 7.
